// File: rtl/cac_link_arbiter.sv
// -----------------------------------------------------------------------------
// cac_link_arbiter
//
// Round-robin transmit scheduler for the 5-TSV Fibonacci CAC link. Two
// requesters share one CAC coder/decoder pair. Each granted word is loaded
// into the coder, allowed to settle, then checked for an exact decoder
// round-trip match and for the forbidden 01/10 FTF patterns on the TSV bus.
// Failed checks are retried up to MAX_RETRY times. Words that still fail are
// acked with an error flag and counted in a saturating error counter.
//
// Ports:
//   clock      - single clock, all logic on the rising edge
//   reset      - synchronous, active-high
//   req_valid  - per-requester request, held until its ack
//   req_data0  - payload for requester 0
//   req_data1  - payload for requester 1
//   req_ack    - one-cycle, one-hot completion pulse
//   ack_err    - qualifies req_ack: 1 = word failed after all retries
//   cac_data   - word presented to the coder datain
//   cac_load   - one-cycle coder clock-enable
//   cac_tsv    - coder TSV outputs
//   cac_dec    - decoder output
//   busy       - high in every state except IDLE
//   err_count  - saturating count of failed words
// -----------------------------------------------------------------------------
module cac_link_arbiter #(
   parameter int DATA_W     = 3,
   parameter int SETTLE_CYC = 2,
   parameter int MAX_RETRY  = 2,
   parameter int CNT_W      = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   output logic [1:0]        req_ack,
   output logic              ack_err,
   output logic [DATA_W-1:0] cac_data,
   output logic              cac_load,
   input  logic [4:0]        cac_tsv,
   input  logic [DATA_W-1:0] cac_dec,
   output logic              busy,
   output logic [CNT_W-1:0]  err_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_CHECK,
      S_ACK
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [2:0] RETRY_LAST  = 3'(MAX_RETRY);

   state_t            state_q,   state_d;
   logic [DATA_W-1:0] word_q,    word_d;     // word under transmission
   logic              grant_q,   grant_d;    // index of the current owner
   logic              last_q,    last_d;     // round-robin pointer
   logic [3:0]        settle_q,  settle_d;
   logic [2:0]        retry_q,   retry_d;
   logic              flag_q,    flag_d;     // error flag reported at ack
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

   logic ftf_viol;
   logic check_pass;
   logic pick;

   // An odd TSV driven high while either even neighbour is low forms a
   // forbidden 01/10 pattern across the shielding wires.
   always_comb begin
      ftf_viol = (cac_tsv[1] & (~cac_tsv[2] | ~cac_tsv[0])) |
                 (cac_tsv[3] & (~cac_tsv[4] | ~cac_tsv[2]));
   end

   assign check_pass = (cac_dec == word_q) && !ftf_viol;

   // On a tie the requester not granted last wins; otherwise the only
   // valid requester is taken.
   assign pick = (&req_valid) ? ~last_q : req_valid[1];

   // NOTE: every variable written in this block gets a default first, so no
   // path through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      grant_d   = grant_q;
      last_d    = last_q;
      settle_d  = settle_q;
      retry_d   = retry_q;
      flag_d    = flag_q;
      err_cnt_d = err_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               grant_d = pick;
               last_d  = pick;
               word_d  = pick ? req_data1 : req_data0;
               retry_d = '0;
               flag_d  = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            settle_d = '0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = S_CHECK;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         S_CHECK: begin
            if (check_pass) begin
               flag_d  = 1'b0;
               state_d = S_ACK;
            end else if (retry_q == RETRY_LAST) begin
               flag_d  = 1'b1;
               if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end
               state_d = S_ACK;
            end else begin
               // Same word is reloaded; the word register is untouched.
               retry_d = retry_q + 3'd1;
               state_d = S_LOAD;
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge value of the others, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         word_q    <= '0;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;  // requester 0 wins the first tie
         settle_q  <= '0;
         retry_q   <= '0;
         flag_q    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         settle_q  <= settle_d;
         retry_q   <= retry_d;
         flag_q    <= flag_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Outputs decode straight from registered state, so they are glitch-free
   // relative to the clock and take their reset values with the state.
   always_comb begin
      req_ack  = 2'b00;
      ack_err  = 1'b0;
      if (state_q == S_ACK) begin
         req_ack = grant_q ? 2'b10 : 2'b01;
         ack_err = flag_q;
      end
   end

   assign cac_load  = (state_q == S_LOAD);
   assign cac_data  = word_q;
   assign busy      = (state_q != S_IDLE);
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_cac_link_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cac_link_arbiter
//
// Directed bench for cac_link_arbiter at default parameters. A behavioural
// coder/decoder model captures cac_data on each cac_load and presents it on
// cac_dec, optionally corrupted for a number of loads; cac_tsv can be forced
// to a violating pattern. Cycle numbers count from the cycle in which
// req_valid is first presented (cycle 0).
// -----------------------------------------------------------------------------
module tb_cac_link_arbiter;

   localparam int DATA_W = 3;
   localparam int CNT_W  = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic [1:0]        req_valid;
   logic [DATA_W-1:0] req_data0;
   logic [DATA_W-1:0] req_data1;
   logic [1:0]        req_ack;
   logic              ack_err;
   logic [DATA_W-1:0] cac_data;
   logic              cac_load;
   logic [4:0]        cac_tsv;
   logic [DATA_W-1:0] cac_dec;
   logic              busy;
   logic [CNT_W-1:0]  err_count;

   int vectors = 0;
   int miscompares = 0;

   // Model state, all driven from the stimulus process.
   int          cyc;
   int          loads;
   int          corrupt_left;
   logic [4:0]  tsv_force;
   int          load_cyc[$];
   logic [DATA_W-1:0] load_dat[$];

   cac_link_arbiter #(
      .DATA_W(DATA_W), .SETTLE_CYC(2), .MAX_RETRY(2), .CNT_W(CNT_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data0 (req_data0),
      .req_data1 (req_data1),
      .req_ack   (req_ack),
      .ack_err   (ack_err),
      .cac_data  (cac_data),
      .cac_load  (cac_load),
      .cac_tsv   (cac_tsv),
      .cac_dec   (cac_dec),
      .busy      (busy),
      .err_count (err_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one cycle and sample 1 time unit after the edge. The coder
   // model latches the word when it sees cac_load and drives the decoder
   // output right away; the DUT only looks at it in CHECK, cycles later.
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (cac_load) begin
         loads++;
         load_cyc.push_back(cyc);
         load_dat.push_back(cac_data);
         cac_dec = cac_data ^ ((corrupt_left > 0) ? 3'b001 : 3'b000);
         if (corrupt_left > 0) corrupt_left--;
         cac_tsv = tsv_force;
      end
   endtask

   task automatic start(input logic [1:0] valid);
      cyc   = 0;
      loads = 0;
      load_cyc.delete();
      load_dat.delete();
      req_valid = valid;
   endtask

   task automatic wait_ack(input int bound, output int at, output logic [1:0] ack,
                           output logic err);
      at  = -1;
      ack = 2'b00;
      err = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (req_ack != 2'b00) begin
            at  = cyc;
            ack = req_ack;
            err = ack_err;
            break;
         end
      end
      if (at < 0) begin
         vectors++;
         miscompares++;
         $display("FAIL ack_timeout: no req_ack within %0d cycles", bound);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   int          at;
   logic [1:0]  ack;
   logic        err;

   initial begin
      reset        = 1'b1;
      req_valid    = 2'b00;
      req_data0    = '0;
      req_data1    = '0;
      cac_tsv      = 5'b00000;
      cac_dec      = '0;
      corrupt_left = 0;
      tsv_force    = 5'b00000;
      cyc          = 0;
      loads        = 0;

      // ---- reset state ----
      do_reset();
      check("rst_req_ack",   32'(req_ack),   0);
      check("rst_ack_err",   32'(ack_err),   0);
      check("rst_cac_load",  32'(cac_load),  0);
      check("rst_cac_data",  32'(cac_data),  0);
      check("rst_busy",      32'(busy),      0);
      check("rst_err_count", 32'(err_count), 0);

      // ---- single requester, clean loopback ----
      req_data0 = 3'd5;
      start(2'b01);
      check("t1_busy_c0", 32'(busy), 0);
      tick();
      check("t1_load_c1", 32'(cac_load), 1);
      check("t1_data_c1", 32'(cac_data), 5);
      check("t1_busy_c1", 32'(busy), 1);
      wait_ack(40, at, ack, err);
      req_valid = 2'b00;
      check("t1_ack_cyc",  32'(at),  5);
      check("t1_ack_val",  32'(ack), 32'b01);
      check("t1_ack_err",  32'(err), 0);
      check("t1_loads",    32'(loads), 1);
      check("t1_errcnt",   32'(err_count), 0);
      tick();
      check("t1_busy_after", 32'(busy), 0);

      // ---- both valid continuously, alternating grants ----
      do_reset();
      req_data0 = 3'd1;
      req_data1 = 3'd2;
      start(2'b11);
      for (int w = 0; w < 4; w++) begin
         wait_ack(40, at, ack, err);
         check($sformatf("t2_ack_cyc%0d", w), 32'(at), 32'(5 + 6 * w));
         check($sformatf("t2_ack_val%0d", w), 32'(ack), (w % 2 == 0) ? 32'b01 : 32'b10);
         check($sformatf("t2_data%0d", w), 32'(load_dat[w]), (w % 2 == 0) ? 32'd1 : 32'd2);
      end
      req_valid = 2'b00;
      tick();

      // ---- decoder corrupt on first load only: one retry ----
      req_data0    = 3'd6;
      corrupt_left = 1;
      start(2'b01);
      wait_ack(40, at, ack, err);
      req_valid = 2'b00;
      check("t3_loads",    32'(loads), 2);
      check("t3_load2cyc", 32'(load_cyc[1]), 5);
      check("t3_ack_cyc",  32'(at), 9);
      check("t3_ack_val",  32'(ack), 32'b01);
      check("t3_ack_err",  32'(err), 0);
      check("t3_errcnt",   32'(err_count), 0);
      tick();

      // ---- FTF violation on every load: retries exhausted ----
      req_data0 = 3'd3;
      tsv_force = 5'b00010;
      start(2'b01);
      wait_ack(60, at, ack, err);
      check("t4_loads",   32'(loads), 3);
      check("t4_load3",   32'(load_cyc[2]), 9);
      check("t4_ack_cyc", 32'(at), 13);
      check("t4_ack_val", 32'(ack), 32'b01);
      check("t4_ack_err", 32'(err), 1);
      check("t4_errcnt",  32'(err_count), 1);
      // Keep requesting; 300 failures in total.
      for (int n = 2; n <= 300; n++) begin
         wait_ack(60, at, ack, err);
         if (n == 254) check("t4_errcnt_254", 32'(err_count), 254);
         if (n == 256) check("t4_errcnt_sat", 32'(err_count), 255);
      end
      check("t4_errcnt_300", 32'(err_count), 255);
      check("t4_err_last",   32'(err), 1);
      req_valid = 2'b00;
      tsv_force = 5'b00000;
      tick();

      // ---- reset in cycle 3 of a transfer ----
      req_data0 = 3'd4;
      req_data1 = 3'd7;
      start(2'b01);
      tick();
      tick();
      tick();
      check("t5_busy_c3", 32'(busy), 1);
      reset = 1'b1;
      tick();
      check("t5_busy_rst",   32'(busy), 0);
      check("t5_ack_rst",    32'(req_ack), 0);
      check("t5_errcnt_rst", 32'(err_count), 0);
      check("t5_load_rst",   32'(cac_load), 0);
      reset = 1'b0;
      start(2'b11);
      tick();
      check("t5_load_c1", 32'(cac_load), 1);
      check("t5_data_c1", 32'(cac_data), 4);
      wait_ack(40, at, ack, err);
      check("t5_ack_val", 32'(ack), 32'b01);
      check("t5_ack_cyc", 32'(at), 5);
      req_valid = 2'b00;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cac_link_arbiter.md
# cac_link_arbiter

Round-robin transmit scheduler for the 5-TSV Fibonacci CAC link. It shares one CAC coder/decoder pair between two requesters and sequences each word through load, settle and check. Each word is checked for an exact decoder round-trip match and for the absence of the forbidden 01/10 FTF patterns on the TSV bus. Failed checks are retried and counted. The block sits between the requester logic and the 5-TSV coder/decoder instances.

## Interface
Parameters:
- DATA_W, 3, payload width (`BLEN_05`)
- SETTLE_CYC, 2, cycles waited after coder load before checking (1..15)
- MAX_RETRY, 2, reloads allowed after a failed check (0..7)
- CNT_W, 8, width of the error counter

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  2  request per requester; held until its ack
- req_data0  in  DATA_W  payload for requester 0
- req_data1  in  DATA_W  payload for requester 1
- req_ack  out  2  one-cycle completion pulse, one-hot
- ack_err  out  1  qualifies req_ack: 1 = word failed after all retries
- cac_data  out  DATA_W  word presented to coder datain
- cac_load  out  1  one-cycle coder clock-enable
- cac_tsv  in  5  coder TSV outputs
- cac_dec  in  DATA_W  decoder output
- busy  out  1  high in every state except IDLE
- err_count  out  CNT_W  saturating count of failed words

## Operation
- States: IDLE, LOAD, SETTLE, CHECK, ACK.
- IDLE
  - If any req_valid bit is set, grant one requester.
  - Latch the winner's data into the word register and record the grant index.
  - Clear the retry counter and go to LOAD.
- Round-robin grant:
  - With both requesters valid, grant the one not granted last.
  - After reset, requester 0 wins the first tie.
  - The last-grant pointer updates only at grant.
- LOAD: cac_load=1 for exactly one cycle; cac_data = word register; go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to CHECK.
- CHECK samples cac_tsv and cac_dec in a single cycle.
  - FTF violation: for m in {1,2}, tsv[2m-1]=1 and (tsv[2m]=0 or tsv[2m-2]=0).
  - Pass: cac_dec == word register and no violation.
  - Pass: go to ACK with error flag 0.
  - Fail with retry count < MAX_RETRY: increment retry, go to LOAD (same word).
  - Fail with retry count == MAX_RETRY: set error flag, increment err_count (saturates at all-ones), go to ACK.
- ACK
  - req_ack[grant]=1 and ack_err=flag for one cycle; go to IDLE.
  - The granted requester's req_valid is not sampled in this cycle.
  - The requester drops or changes req_valid on the cycle after the ack.
- cac_data holds the word register value from grant until the next grant. The coder never sees a changing word during settle.
- A req_valid drop before ack is a protocol violation. The block completes the word regardless.

## Timing
- Reset values:
  - State IDLE, req_ack=0, ack_err=0, cac_load=0, cac_data=0, busy=0.
  - err_count=0, retry counter=0, last-grant pointer set so requester 0 wins the first tie.
- Reset mid-operation returns to IDLE the next cycle. No ack is issued for the in-flight word. err_count clears.
- Cycle numbering, with req_valid first seen high at cycle 0 (IDLE):
  - Cycle 0: grant.
  - Cycle 1: cac_load=1.
  - Cycles 2..1+SETTLE_CYC: settle.
  - Cycle 2+SETTLE_CYC: CHECK.
  - Cycle 3+SETTLE_CYC: req_ack.
- Latency, no retry: 3+SETTLE_CYC cycles (5 at default).
- Each retry adds 2+SETTLE_CYC cycles (LOAD + SETTLE + CHECK).
- Earliest next grant is in the cycle after ACK.
- Back-to-back pace with both valid: one word per 4+SETTLE_CYC cycles, alternating requesters.
- busy rises the cycle after grant and falls in the cycle after ACK.

## Test plan
- Single requester, loopback coder/decoder model, req_data0=5, SETTLE_CYC=2
  - cac_load at cycle 1, req_ack=2'b01 at cycle 5, ack_err=0, err_count=0.
- Both valid continuously, data 1 and 2
  - Grants alternate 0,1,0,1.
  - Acks at cycles 5, 11, 17, 23.
  - cac_data matches the granted requester each time.
- Decoder model forced to return word XOR 1 on the first load only
  - One retry: second cac_load at cycle 5, ack at cycle 9, ack_err=0.
- cac_tsv forced to 5'b00010 (FTF violation) for all loads, MAX_RETRY=2
  - Three cac_load pulses, ack with ack_err=1, err_count=1.
  - 300 such failures saturate err_count at 255.
- Reset asserted in cycle 3 of a transfer
  - Next cycle: IDLE, busy=0, no req_ack, err_count=0.
  - With both requesters then valid, requester 0 is granted first.
